// File: rtl/trashbin_lsu_pkg.sv
// rtl/trashbin_lsu_pkg.sv - shared encodings for the trashbin load/store unit
// Contents: access-width codes (ReqWidth), fault codes (RespFaultCode) and the
// sequencer state encoding. No ports.

package trashbin_lsu_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE  = 2'b00,
        WIDTH_HALF  = 2'b01,
        WIDTH_WORD  = 2'b10,
        WIDTH_DWORD = 2'b11
    } access_width_e;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_ILLEGAL    = 2'b10,
        FAULT_TIMEOUT    = 2'b11
    } fault_code_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_RESP  = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/trashbin_lsu_lane.sv
// rtl/trashbin_lsu_lane.sv - combinational byte-lane steering for the LSU
// Parameters: XLEN (32 or 64).
// Ports:
//   width       in   access width code (byte/half/word/dword)
//   offset      in   byte offset of the access inside the bus word
//   sign_ext    in   sign-extend the extracted load value
//   write_data  in   right-aligned store data
//   read_data   in   raw bus read data
//   byte_en     out  lanes covered by the access
//   write_lanes out  store data replicated into every lane of its width
//   read_ext    out  extracted and extended load value

module trashbin_lsu_lane #(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]       width,
    input  logic [OFF_W-1:0] offset,
    input  logic             sign_ext,
    input  logic [XLEN-1:0]  write_data,
    input  logic [XLEN-1:0]  read_data,
    output logic [NB-1:0]    byte_en,
    output logic [XLEN-1:0]  write_lanes,
    output logic [XLEN-1:0]  read_ext
);

    logic [XLEN-1:0] shifted;
    logic            fill;
    int              lane_bytes;
    int              load_bits;

    always_comb begin
        byte_en     = '0;
        write_lanes = '0;
        read_ext    = '0;

        lane_bytes = 32'(1) << width;
        // A dword code on a 32-bit bus is rejected upstream; clamp so the
        // extension logic never indexes past the bus.
        load_bits = 8 * lane_bytes;
        if (load_bits > XLEN) begin
            load_bits = XLEN;
        end

        // Lane i belongs to the access when it sits in the same naturally
        // aligned group of lane_bytes lanes as the offset.
        for (int i = 0; i < NB; i++) begin
            byte_en[i] = ((i >> width) == (int'(offset) >> width));
            write_lanes[8*i +: 8] = write_data[8*(i & (lane_bytes - 1)) +: 8];
        end

        shifted = read_data >> {offset, 3'b000};
        fill    = sign_ext & shifted[load_bits-1];
        for (int b = 0; b < XLEN; b++) begin
            read_ext[b] = (b < load_bits) ? shifted[b] : fill;
        end
    end

endmodule

// File: rtl/trashbin_lsu.sv
// rtl/trashbin_lsu.sv - handshaked load/store sequencer for the Trashbin core
// Parameters: XLEN (32/64), ADDR_W, TIMEOUT_CYCLES (used only when the
// TRASHBIN_LSU_TIMEOUT_EN macro is defined; otherwise the LSU waits forever).
// Ports:
//   CoreClock, CoreReset                 clock, async active-high reset
//   ReqValid/ReqReady                    request handshake from execute
//   ReqWrite, ReqWidth, ReqSignExtend    access kind
//   ReqAddress, ReqWriteData             byte address, right-aligned store data
//   RespValid, RespData                  one-cycle completion, extended load data
//   RespFault, RespFaultCode             fault flag and code
//   AddressBus, DataWriteBus, ByteEnable aligned bus address, lane data, lanes
//   ReadAssert/WriteAssert               memory strobes
//   DataReadBus, ReadOK/WriteOK          memory read data and acknowledges

module trashbin_lsu
    import trashbin_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 CoreClock,
    input  logic                 CoreReset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [1:0]           ReqWidth,
    input  logic                 ReqSignExtend,
    input  logic [ADDR_W-1:0]    ReqAddress,
    input  logic [XLEN-1:0]      ReqWriteData,
    output logic                 RespValid,
    output logic [XLEN-1:0]      RespData,
    output logic                 RespFault,
    output logic [1:0]           RespFaultCode,
    output logic [ADDR_W-1:0]    AddressBus,
    output logic [XLEN-1:0]      DataWriteBus,
    output logic [XLEN/8-1:0]    ByteEnable,
    output logic                 ReadAssert,
    output logic                 WriteAssert,
    input  logic [XLEN-1:0]      DataReadBus,
    input  logic                 ReadOK,
    input  logic                 WriteOK
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e       state;
    logic [1:0]       req_width;
    logic [OFF_W-1:0] req_offset;
    logic             req_sign;

    logic [1:0]       lane_width;
    logic [OFF_W-1:0] lane_offset;
    logic [NB-1:0]    lane_be;
    logic [XLEN-1:0]  lane_wdata;
    logic [XLEN-1:0]  lane_rdata;

    logic             misaligned;
    logic             illegal;

`ifdef TRASHBIN_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;

    // Expires on the edge that ends the TIMEOUT_CYCLES-th strobe cycle.
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No counter in this build; the parameter only keeps the interface uniform.
    if (TIMEOUT_CYCLES < 0) begin : g_unused_timeout
    end
`endif

    // One lane instance serves both directions: in IDLE it steers the incoming
    // store, afterwards it extracts the load using the registered request.
    assign lane_width  = (state == S_IDLE) ? ReqWidth : req_width;
    assign lane_offset = (state == S_IDLE) ? ReqAddress[OFF_W-1:0] : req_offset;

    trashbin_lsu_lane #(
        .XLEN (XLEN)
    ) u_lane (
        .width       (lane_width),
        .offset      (lane_offset),
        .sign_ext    (req_sign),
        .write_data  (ReqWriteData),
        .read_data   (DataReadBus),
        .byte_en     (lane_be),
        .write_lanes (lane_wdata),
        .read_ext    (lane_rdata)
    );

    always_comb begin
        illegal    = (ReqWidth == WIDTH_DWORD) && (XLEN == 32);
        misaligned = 1'b0;
        case (ReqWidth)
            WIDTH_HALF:  misaligned = ReqAddress[0];
            WIDTH_WORD:  misaligned = |ReqAddress[1:0];
            WIDTH_DWORD: misaligned = |ReqAddress[2:0];
            default:     misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge CoreClock or posedge CoreReset) begin
        if (CoreReset) begin
            state         <= S_IDLE;
            req_width     <= '0;
            req_offset    <= '0;
            req_sign      <= 1'b0;
            ReqReady      <= 1'b1;
            RespValid     <= 1'b0;
            RespData      <= '0;
            RespFault     <= 1'b0;
            RespFaultCode <= FAULT_NONE;
            AddressBus    <= '0;
            DataWriteBus  <= '0;
            ByteEnable    <= '0;
            ReadAssert    <= 1'b0;
            WriteAssert   <= 1'b0;
`ifdef TRASHBIN_LSU_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ReqValid && ReqReady) begin
                        ReqReady   <= 1'b0;
                        req_width  <= ReqWidth;
                        req_offset <= ReqAddress[OFF_W-1:0];
                        req_sign   <= ReqSignExtend;
`ifdef TRASHBIN_LSU_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                        // Illegal width outranks misalignment.
                        if (illegal || misaligned) begin
                            state         <= S_RESP;
                            RespValid     <= 1'b1;
                            RespFault     <= 1'b1;
                            RespData      <= '0;
                            RespFaultCode <= illegal ? FAULT_ILLEGAL : FAULT_MISALIGNED;
                        end else begin
                            state        <= ReqWrite ? S_WRITE : S_READ;
                            ReadAssert   <= ~ReqWrite;
                            WriteAssert  <= ReqWrite;
                            AddressBus   <= {ReqAddress[ADDR_W-1:OFF_W], OFF_W'(0)};
                            ByteEnable   <= lane_be;
                            DataWriteBus <= ReqWrite ? lane_wdata : '0;
                        end
                    end
                end

                S_READ, S_WRITE: begin
                    // Only the acknowledge matching the current direction counts;
                    // it also beats a timeout expiring on the same edge.
                    if ((state == S_READ) ? ReadOK : WriteOK) begin
                        state         <= S_RESP;
                        RespValid     <= 1'b1;
                        RespFault     <= 1'b0;
                        RespFaultCode <= FAULT_NONE;
                        RespData      <= (state == S_READ) ? lane_rdata : '0;
                        ReadAssert    <= 1'b0;
                        WriteAssert   <= 1'b0;
                        AddressBus    <= '0;
                        ByteEnable    <= '0;
                        DataWriteBus  <= '0;
`ifdef TRASHBIN_LSU_TIMEOUT_EN
                    end else if (wait_expired) begin
                        state         <= S_RESP;
                        RespValid     <= 1'b1;
                        RespFault     <= 1'b1;
                        RespFaultCode <= FAULT_TIMEOUT;
                        RespData      <= '0;
                        ReadAssert    <= 1'b0;
                        WriteAssert   <= 1'b0;
                        AddressBus    <= '0;
                        ByteEnable    <= '0;
                        DataWriteBus  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end

                S_RESP: begin
                    state         <= S_IDLE;
                    ReqReady      <= 1'b1;
                    RespValid     <= 1'b0;
                    RespFault     <= 1'b0;
                    RespFaultCode <= FAULT_NONE;
                    RespData      <= '0;
                end

                default: begin
                    state    <= S_IDLE;
                    ReqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trashbin_lsu.sv
// tb/tb_trashbin_lsu.sv - directed self-checking bench for trashbin_lsu (XLEN 32 and 64)

module tb_trashbin_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 32-bit instance
    logic        req_valid = 0, req_ready, req_write = 0, req_sign = 0;
    logic [1:0]  req_width = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_data;
    logic [1:0]  resp_code;
    logic [31:0] addr_bus, wr_bus;
    logic [3:0]  byte_en;
    logic        read_assert, write_assert;
    logic [31:0] rd_bus = 0;
    logic        read_ok = 0, write_ok = 0;

    // 64-bit instance
    logic        x_req_valid = 0, x_req_ready, x_req_write = 0, x_req_sign = 0;
    logic [1:0]  x_req_width = 0;
    logic [31:0] x_req_addr = 0;
    logic [63:0] x_req_wdata = 0;
    logic        x_resp_valid, x_resp_fault;
    logic [63:0] x_resp_data;
    logic [1:0]  x_resp_code;
    logic [31:0] x_addr_bus;
    logic [63:0] x_wr_bus;
    logic [7:0]  x_byte_en;
    logic        x_read_assert, x_write_assert;
    logic [63:0] x_rd_bus = 0;
    logic        x_read_ok = 0, x_write_ok = 0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trashbin_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .CoreClock(clk), .CoreReset(rst),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqWrite(req_write),
        .ReqWidth(req_width), .ReqSignExtend(req_sign), .ReqAddress(req_addr),
        .ReqWriteData(req_wdata), .RespValid(resp_valid), .RespData(resp_data),
        .RespFault(resp_fault), .RespFaultCode(resp_code), .AddressBus(addr_bus),
        .DataWriteBus(wr_bus), .ByteEnable(byte_en), .ReadAssert(read_assert),
        .WriteAssert(write_assert), .DataReadBus(rd_bus), .ReadOK(read_ok),
        .WriteOK(write_ok)
    );

    trashbin_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut64 (
        .CoreClock(clk), .CoreReset(rst),
        .ReqValid(x_req_valid), .ReqReady(x_req_ready), .ReqWrite(x_req_write),
        .ReqWidth(x_req_width), .ReqSignExtend(x_req_sign), .ReqAddress(x_req_addr),
        .ReqWriteData(x_req_wdata), .RespValid(x_resp_valid), .RespData(x_resp_data),
        .RespFault(x_resp_fault), .RespFaultCode(x_resp_code), .AddressBus(x_addr_bus),
        .DataWriteBus(x_wr_bus), .ByteEnable(x_byte_en), .ReadAssert(x_read_assert),
        .WriteAssert(x_write_assert), .DataReadBus(x_rd_bus), .ReadOK(x_read_ok),
        .WriteOK(x_write_ok)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus access on the 32-bit unit; the matching OK arrives in strobe cycle waits+1,
    // the opposite OK is driven high in every earlier cycle and must be ignored.
    task automatic bus32(input string tag, input logic wr, input logic [1:0] w, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int waits, input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wbus, input logic [31:0] e_data);
        req_valid = 1; req_write = wr; req_width = w; req_sign = sx;
        req_addr = a; req_wdata = wd; rd_bus = rd;
        tick();
        req_valid = 0;
        for (int i = 0; i <= waits; i++) begin
            chk({tag, ".strobe"}, wr ? write_assert : read_assert, 1'b1);
            chk({tag, ".addr"}, addr_bus, e_addr);
            chk({tag, ".be"}, byte_en, e_be);
            chk({tag, ".wbus"}, wr_bus, e_wbus);
            chk({tag, ".early_valid"}, resp_valid, 1'b0);
            if (i == waits) begin
                if (wr) write_ok = 1; else read_ok = 1;
            end else begin
                if (wr) read_ok = 1; else write_ok = 1;
            end
            tick();
            read_ok = 0; write_ok = 0;
        end
        chk({tag, ".resp_valid"}, resp_valid, 1'b1);
        chk({tag, ".resp_fault"}, resp_fault, 1'b0);
        chk({tag, ".resp_data"}, resp_data, e_data);
        chk({tag, ".strobe_off"}, {read_assert, write_assert}, 2'b00);
        tick();
        chk({tag, ".pulse_end"}, resp_valid, 1'b0);
        chk({tag, ".ready"}, req_ready, 1'b1);
    endtask

    task automatic fault32(input string tag, input logic [1:0] w, input logic [31:0] a,
                           input logic [1:0] e_code);
        req_valid = 1; req_write = 0; req_width = w; req_sign = 0; req_addr = a;
        tick();
        req_valid = 0;
        chk({tag, ".resp_valid"}, resp_valid, 1'b1);
        chk({tag, ".resp_fault"}, resp_fault, 1'b1);
        chk({tag, ".code"}, resp_code, e_code);
        chk({tag, ".no_strobe"}, {read_assert, write_assert}, 2'b00);
        chk({tag, ".data"}, resp_data, 32'h0);
        tick();
        chk({tag, ".pulse_end"}, resp_valid, 1'b0);
        chk({tag, ".ready"}, req_ready, 1'b1);
    endtask

    // Single-cycle-OK access on the 64-bit unit.
    task automatic bus64(input string tag, input logic wr, input logic [1:0] w, input logic sx,
                         input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                         input logic [31:0] e_addr, input logic [7:0] e_be,
                         input logic [63:0] e_wbus, input logic [63:0] e_data);
        x_req_valid = 1; x_req_write = wr; x_req_width = w; x_req_sign = sx;
        x_req_addr = a; x_req_wdata = wd; x_rd_bus = rd;
        tick();
        x_req_valid = 0;
        chk({tag, ".strobe"}, wr ? x_write_assert : x_read_assert, 1'b1);
        chk({tag, ".addr"}, x_addr_bus, e_addr);
        chk({tag, ".be"}, x_byte_en, e_be);
        chk({tag, ".wbus"}, x_wr_bus, e_wbus);
        if (wr) x_write_ok = 1; else x_read_ok = 1;
        tick();
        x_read_ok = 0; x_write_ok = 0;
        chk({tag, ".resp_valid"}, x_resp_valid, 1'b1);
        chk({tag, ".resp_fault"}, x_resp_fault, 1'b0);
        chk({tag, ".resp_data"}, x_resp_data, e_data);
        tick();
        chk({tag, ".pulse_end"}, x_resp_valid, 1'b0);
    endtask

    initial begin
        int strobes;

        // Reset state
        tick(); tick();
        chk("rst.ready", req_ready, 1'b1);
        chk("rst.valid", resp_valid, 1'b0);
        chk("rst.strobes", {read_assert, write_assert}, 2'b00);
        chk("rst.addr", addr_bus, 32'h0);
        chk("rst.be", byte_en, 4'h0);
        chk("rst.wbus", wr_bus, 32'h0);
        chk("rst.data", resp_data, 32'h0);
        chk("rst.fault", {resp_fault, resp_code}, 3'b000);
        chk("rst64.ready", x_req_ready, 1'b1);
        chk("rst64.be", x_byte_en, 8'h00);
        rst = 0;
        tick();

        // Loads on the 32-bit unit
        bus32("lb_signed", 0, 2'b00, 1, 32'h1003, 32'h0, 32'h80FF_FF11, 0,
              32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        bus32("lbu", 0, 2'b00, 0, 32'h1001, 32'h0, 32'h0000_8000, 0,
              32'h1000, 4'b0010, 32'h0, 32'h0000_0080);
        bus32("lh_signed", 0, 2'b01, 1, 32'h1002, 32'h0, 32'h8001_0000, 1,
              32'h1000, 4'b1100, 32'h0, 32'hFFFF_8001);

        // Stores on the 32-bit unit
        bus32("sh_wait3", 1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 32'h0, 3,
              32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        bus32("sb", 1, 2'b00, 0, 32'h2001, 32'h1234_56A5, 32'h0, 0,
              32'h2000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        bus32("sw", 1, 2'b10, 0, 32'h2004, 32'hCAFE_F00D, 32'h0, 0,
              32'h2004, 4'b1111, 32'hCAFE_F00D, 32'h0);

        // Fault paths
        fault32("lw_misaligned", 2'b10, 32'h3001, 2'b01);
        fault32("lh_misaligned", 2'b01, 32'h3003, 2'b01);
        fault32("dword_illegal", 2'b11, 32'h4000, 2'b10);

        // Reset during READ
        req_valid = 1; req_write = 0; req_width = 2'b10; req_addr = 32'h5000;
        tick();
        req_valid = 0;
        chk("rst_mid.read_on", read_assert, 1'b1);
        rst = 1;
        #1;
        chk("rst_mid.read_drop", read_assert, 1'b0);
        chk("rst_mid.no_valid", resp_valid, 1'b0);
        tick();
        rst = 0;
        tick();
        chk("rst_mid.ready", req_ready, 1'b1);
        chk("rst_mid.no_valid_after", resp_valid, 1'b0);
        read_ok = 1;
        tick();
        read_ok = 0;
        chk("idle_ok.ignored_valid", resp_valid, 1'b0);
        chk("idle_ok.ignored_ready", req_ready, 1'b1);
        bus32("lw_after_rst", 0, 2'b10, 0, 32'h0, 32'h0, 32'h1234_5678, 0,
              32'h0, 4'b1111, 32'h0, 32'h1234_5678);

`ifdef TRASHBIN_LSU_TIMEOUT_EN
        // No ReadOK: strobe must stay exactly TIMEOUT_CYCLES (4) cycles.
        req_valid = 1; req_write = 0; req_width = 2'b10; req_addr = 32'h100;
        tick();
        req_valid = 0;
        strobes = 0;
        for (int i = 0; i < 12 && !resp_valid; i++) begin
            if (read_assert) strobes++;
            tick();
        end
        chk("timeout.strobe_cycles", strobes, 4);
        chk("timeout.valid", resp_valid, 1'b1);
        chk("timeout.fault", {resp_fault, resp_code}, 3'b111);
        chk("timeout.data", resp_data, 32'h0);
        tick();
        chk("timeout.ready", req_ready, 1'b1);
        bus32("ok_on_expiry", 0, 2'b10, 0, 32'h104, 32'h0, 32'h0BAD_F00D, 3,
              32'h104, 4'b1111, 32'h0, 32'h0BAD_F00D);
`else
        strobes = 0;
        chk("no_timeout.counter", strobes, 0);
        bus32("long_wait", 0, 2'b10, 0, 32'h104, 32'h0, 32'h0BAD_F00D, 8,
              32'h104, 4'b1111, 32'h0, 32'h0BAD_F00D);
`endif

        // 64-bit unit
        bus64("ld", 0, 2'b11, 0, 32'h10, 64'h0, 64'h8001_0000_0000_0000,
              32'h10, 8'hFF, 64'h0, 64'h8001_0000_0000_0000);
        bus64("lhu", 0, 2'b01, 0, 32'h16, 64'h0, 64'h8001_0000_0000_0000,
              32'h10, 8'hC0, 64'h0, 64'h0000_0000_0000_8001);
        bus64("lw_signed", 0, 2'b10, 1, 32'h4, 64'h0, 64'h8000_0000_0000_0000,
              32'h0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000);
        bus64("sw", 1, 2'b10, 0, 32'h4, 64'h0000_0000_DEAD_BEEF, 64'h0,
              32'h0, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0);
        bus64("sb", 1, 2'b00, 0, 32'h7, 64'h0000_0000_0000_005A, 64'h0,
              32'h0, 8'h80, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0);

        x_req_valid = 1; x_req_write = 0; x_req_width = 2'b11; x_req_addr = 32'h14;
        tick();
        x_req_valid = 0;
        chk("ld_misaligned.valid", x_resp_valid, 1'b1);
        chk("ld_misaligned.code", {x_resp_fault, x_resp_code}, 3'b101);
        chk("ld_misaligned.no_strobe", x_read_assert, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trashbin_lsu.md
# trashbin_lsu

Parametrised load/store unit for the Trashbin core. It replaces the core's single-phase, word-only memory path with a handshaked sequencer that supports byte, half, word and (at XLEN=64) dword accesses. The sequencer holds the bus until the memory acknowledges, and reports misaligned, illegal or timed-out accesses as faults instead of locking up. It sits between the core's execute phase and the CPU data interface.

## Interface
- XLEN, 32: data width; 32 or 64.
- ADDR_W, 32: address width.
- TIMEOUT_CYCLES, 255: maximum number of wait cycles in READ/WRITE; only used when the timeout feature is compiled in.

- CoreClock  in  1  single clock; all state updates on the rising edge.
- CoreReset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  core issues an access.
- ReqReady  out  1  LSU can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqWidth  in  2  00 byte, 01 half, 10 word, 11 dword.
- ReqSignExtend  in  1  sign-extend the load result.
- ReqAddress  in  ADDR_W  byte address.
- ReqWriteData  in  XLEN  store data, right-aligned.
- RespValid  out  1  one-cycle completion pulse.
- RespData  out  XLEN  extended load data; 0 for stores and faults.
- RespFault  out  1  access failed.
- RespFaultCode  out  2  00 none, 01 misaligned, 10 illegal width, 11 timeout.
- AddressBus  out  ADDR_W  aligned address; low log2(XLEN/8) bits are zero.
- DataWriteBus  out  XLEN  lane-replicated store data.
- ByteEnable  out  XLEN/8  active lanes.
- ReadAssert / WriteAssert  out  1  memory strobes.
- DataReadBus  in  XLEN  memory read data.
- ReadOK / WriteOK  in  1  memory acknowledge.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Reset values: state IDLE, ReqReady 1, every other output 0.
- ReqReady is 1 only in IDLE. A request is accepted when ReqValid & ReqReady.
- On accept, the request is registered and checked:
  - ReqWidth=11 with XLEN=32: illegal width, fault 10.
  - Misaligned access: half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0. Fault 01.
  - Any fault goes straight to RESP with no bus strobe.
  - Otherwise the next state is READ or WRITE.
- READ/WRITE:
  - Strobe plus AddressBus, ByteEnable and DataWriteBus are held stable until the matching OK is sampled high.
  - ReadOK in WRITE, WriteOK in READ, and any OK in IDLE/RESP are ignored.
- Store lanes:
  - Byte data is replicated into every byte lane; half data into every half lane; word data into every word lane.
  - ByteEnable selects the lanes at the address offset.
- Load: the lane at the address offset is extracted, then sign- or zero-extended to XLEN. It is latched on the ReadOK edge.
- RESP: RespValid is high for exactly one cycle, then the state returns to IDLE.

## Timing
- Accept → first strobe cycle: 1 cycle.
- OK sampled → RespValid: 1 cycle.
- Minimum accept → RespValid for a bus access: 2 cycles (OK in the first strobe cycle).
- Fault path: RespValid 1 cycle after accept.
- Minimum request spacing: 3 cycles.
- Reset asserted mid-operation: strobes and RespValid drop immediately (asynchronously); no response is produced; ReqReady is 1 after reset deassertion.
- OK arriving in the same cycle the timeout expires: OK wins and the access completes normally.

## Configuration
- TRASHBIN_LSU_TIMEOUT_EN defined:
  - A wait counter increments every cycle spent in READ/WRITE.
  - If no OK has arrived after TIMEOUT_CYCLES strobe cycles, the strobe drops, the state goes to RESP, and fault 11 is reported.
- TRASHBIN_LSU_TIMEOUT_EN undefined:
  - The LSU waits indefinitely for OK.
  - Fault code 11 is never produced, and no counter is built.

## Structure
- Package trashbin_lsu_pkg holds:
  - access-width encodings;
  - fault-code encodings;
  - state encoding.
- Sub-module trashbin_lsu_lane: combinational lane logic. It produces byte enables, store replication and load extraction/extension, and is parametrised by XLEN.

## Test plan
- LB signed, 0x1003, DataReadBus 0x80FF_FF11, ReadOK in first READ cycle → AddressBus 0x1000, ByteEnable 1000, RespData 0xFFFF_FF80, RespValid 2 cycles after accept.
- SH 0x2002, data 0x0000_BEEF, WriteOK after 3 wait cycles → DataWriteBus 0xBEEF_BEEF, ByteEnable 1100 for 4 cycles, RespValid 5 cycles after accept, RespFault 0.
- LW 0x3001 → no ReadAssert, RespValid+RespFault code 01 one cycle after accept; ReqWidth=11 at XLEN=32 → code 10.
- TRASHBIN_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ReadOK → ReadAssert high exactly 4 cycles, then fault 11; repeat with ReadOK on the 4th cycle → normal completion.
- CoreReset pulsed during READ → ReadAssert low immediately, no RespValid, ReqReady 1 after release; next LW 0x0 completes normally.
- XLEN=64, LD 0x10, LHU 0x16 with data 0x8001_0000_0000_0000 → dword returned intact; LHU RespData 0x0000_0000_0000_8001.
